// File: rtl/gr_heep_ext_obi_mem_responder.sv
// OBI responder: word-addressed byte-enable SRAM with a fixed-latency in-order response pipeline.
// Optional range checking with err_o is enabled by defining GR_HEEP_EXT_OBI_ERR_EN.
module gr_heep_ext_obi_mem_responder #(
  parameter int unsigned NumWords = 1024,
  parameter int unsigned Latency  = 1,
  parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic        stall_i
`ifdef GR_HEEP_EXT_OBI_ERR_EN
  ,
  output logic        err_o
`endif
);

  localparam int unsigned AW = $clog2(NumWords);

  logic [31:0]         off;
  logic [AW-1:0]       idx;
  logic                accept;
  logic                oor;
  logic [31:0]         mem [NumWords];
  logic [Latency-1:0]  valid_q;
  logic [Latency-1:0]  err_q;
  logic [31:0]         rdata_q [Latency];
  logic                unused_bits;

  assign gnt_o  = req_i & ~stall_i & ~rst_i;
  assign accept = req_i & gnt_o;
  assign off    = addr_i - BaseAddr;
  assign idx    = off[AW+1:2];

`ifdef GR_HEEP_EXT_OBI_ERR_EN
  assign oor         = |off[31:AW+2];
  assign err_o       = err_q[Latency-1];
  assign unused_bits = ^off[1:0];
`else
  // Without range checking the upper offset bits simply alias onto the array.
  assign oor         = 1'b0;
  assign unused_bits = ^{off[31:AW+2], off[1:0], err_q[Latency-1]};
`endif

  // Memory contents are deliberately not reset so they survive rst_i.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && !oor) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (be_i[k]) mem[idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int unsigned i = 0; i < Latency; i++) rdata_q[i] <= '0;
    end else begin
      valid_q[0] <= accept;
      err_q[0]   <= accept & oor;
      rdata_q[0] <= (accept && !we_i && !oor) ? mem[idx] : '0;
      for (int unsigned i = 1; i < Latency; i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
        rdata_q[i] <= rdata_q[i-1];
      end
    end
  end

  assign rvalid_o = valid_q[Latency-1];
  assign rdata_o  = rdata_q[Latency-1];

endmodule
